// File: rtl/branch_sequencer_if.sv
// rtl/branch_sequencer_if.sv - instruction fetch and execute handshake bundle for branch_sequencer
//
// Fetch side : imem_req/imem_addr (sequencer -> memory), imem_ack/imem_data (memory -> sequencer)
// Issue side : instr/instr_valid (sequencer -> datapath)
// Exec side  : exec_done/is_branch/compres/branch_target/halt_in (datapath -> sequencer)
// master = sequencer, slave = memory + datapath.

interface branch_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        is_branch;
    logic        compres;
    logic [15:0] branch_target;
    logic        halt_in;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_data, exec_done, is_branch, compres, branch_target, halt_in
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_data, exec_done, is_branch, compres, branch_target, halt_in
    );
endinterface

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - program counter and fetch/issue/execute sequencer with branch handling
//
// Ports:
//   clock, reset_n  : rising-edge clock, asynchronous active-low reset
//   start           : begin execution from RESET_PC (only from IDLE or HALTED)
//   bus             : fetch / issue / execute handshakes (master side)
//   pc              : current program counter (also drives imem_addr)
//   running, halted : state summary flags
//   fetch_err       : sticky fetch-timeout fault, cleared by start
//   taken_count     : saturating count of taken branches since last start

module branch_sequencer #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int          COUNT_W       = 8,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    branch_sequencer_if.master  bus,
    output logic [15:0]         pc,
    output logic                running,
    output logic                halted,
    output logic                fetch_err,
    output logic [COUNT_W-1:0]  taken_count
);
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_EXEC, HALTED} state_t;

    state_t             state, state_nxt;
    logic [15:0]        pc_nxt;
    logic [15:0]        instr_q, instr_nxt;
    logic [COUNT_W-1:0] cnt_nxt;
    logic [TW-1:0]      tmo, tmo_nxt;
    logic               err_nxt;

    // The address is the PC register itself, so it is stable for all of FETCH.
    assign bus.imem_addr = pc;
    assign bus.instr     = instr_q;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
        cnt_nxt   = taken_count;
        tmo_nxt   = tmo;
        err_nxt   = fetch_err;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_nxt    = RESET_PC;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    tmo_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // An ack on the last allowed cycle is checked first, so it wins over the fault.
                if (bus.imem_ack) begin
                    instr_nxt = bus.imem_data;
                    state_nxt = ISSUE;
                end else if (tmo == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = HALTED;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_EXEC;
            end
            WAIT_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.halt_in) begin
                        state_nxt = HALTED;
                    end else begin
                        if (bus.is_branch && bus.compres) begin
                            pc_nxt = bus.branch_target;
                            if (taken_count != '1)
                                cnt_nxt = taken_count + 1'b1;
                        end else begin
                            pc_nxt = pc + 16'd1;
                        end
                        tmo_nxt   = '0;
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            instr_q         <= '0;
            taken_count     <= '0;
            tmo             <= '0;
            fetch_err       <= 1'b0;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b0;
            running         <= 1'b0;
            halted          <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            instr_q         <= instr_nxt;
            taken_count     <= cnt_nxt;
            tmo             <= tmo_nxt;
            fetch_err       <= err_nxt;
            bus.imem_req    <= (state_nxt == FETCH);
            bus.instr_valid <= (state_nxt == ISSUE);
            running         <= (state_nxt == FETCH) || (state_nxt == ISSUE) || (state_nxt == WAIT_EXEC);
            halted          <= (state_nxt == HALTED);
        end
    end
endmodule
